// File: rtl/fwd_sel_ctrl.sv
// Operand-mux select arbiter with load-use stall FSM.
// Forwarded selects override control selects; result registered into ID/EX.
module fwd_sel_ctrl #(
  parameter int               NUM_SRC   = 2,
  parameter int               SEL_W     = 3,
  parameter logic [SEL_W-1:0] LDU_CODE  = 3'b110,
  parameter int               STALL_CYC = 1,
  parameter int               PERF_W    = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     en,
  input  logic                     flush,
  input  logic                     ld_in_ex,
  input  logic [NUM_SRC*SEL_W-1:0] sel_cu,
  input  logic [NUM_SRC*SEL_W-1:0] sel_fh,
  output logic [NUM_SRC*SEL_W-1:0] sel,
  output logic                     stall,
  output logic                     bubble,
  output logic [PERF_W-1:0]        stall_cnt
);

  localparam int CNT_W =
    (STALL_CYC > 1) ? $clog2(STALL_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'((STALL_CYC > 0) ? STALL_CYC - 1 : 0);
  localparam logic STALL_EN = (STALL_CYC != 0);
  localparam logic [PERF_W-1:0] PERF_MAX = '1;

  typedef enum logic {RUN, STALL} state_t;

  state_t                     state;
  logic [CNT_W-1:0]           cnt;
  logic [NUM_SRC*SEL_W-1:0]   pick;
  logic [NUM_SRC-1:0]         ldu_hit;
  logic                       hazard;

  always_comb begin
    pick    = '0;
    ldu_hit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pick[i*SEL_W+:SEL_W] =
        sel_fh[i*SEL_W+SEL_W-1] ? sel_fh[i*SEL_W+:SEL_W]
                                : sel_cu[i*SEL_W+:SEL_W];
      ldu_hit[i] = (sel_fh[i*SEL_W+:SEL_W] == LDU_CODE);
    end
  end

  assign hazard = ld_in_ex & STALL_EN & (|ldu_hit);

  // STALL parks for one extra, non-stalling cycle once cnt drains
  assign stall = (state == RUN) ? hazard : (cnt != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel       <= '0;
      bubble    <= 1'b0;
      stall_cnt <= '0;
      state     <= RUN;
      cnt       <= '0;
    end else if (en) begin
      if (flush) begin
        sel    <= '0;
        bubble <= 1'b1;
        state  <= RUN;
        cnt    <= '0;
      end else begin
        if (stall) begin
          sel    <= '0;
          bubble <= 1'b1;
          if (stall_cnt != PERF_MAX)
            stall_cnt <= stall_cnt + PERF_W'(1);
        end else begin
          sel    <= pick;
          bubble <= 1'b0;
        end
        unique case (state)
          RUN: begin
            if (hazard) begin
              state <= STALL;
              cnt   <= CNT_INIT;
            end
          end
          STALL: begin
            if (cnt != '0) cnt <= cnt - CNT_W'(1);
            else           state <= RUN;
          end
          default: state <= RUN;
        endcase
      end
    end
  end

endmodule
